// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes ALU instructions, holds operands for a fixed latency and returns the captured result
module alu_issue_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_alu_op,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result_in,
  input  logic        alu_zero_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_illegal
);
  localparam int CW = MUL_LATENCY > 1 ? $clog2(MUL_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] ctl_q, ctl_d, dec;
  logic zero_q, zero_d, ill_q, ill_d, legal;
  always_comb begin
    legal = !in_alu_op[1] || (in_alu_op == 2'b10 && in_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000});
    dec = in_alu_op == 2'b00 ? 3'b010 :
          in_alu_op == 2'b01 ? 3'b110 :
          in_funct == 6'b100010 ? 3'b110 :
          in_funct == 6'b100100 ? 3'b000 :
          in_funct == 6'b100101 ? 3'b001 :
          in_funct == 6'b101010 ? 3'b111 :
          in_funct == 6'b011000 ? 3'b101 : 3'b010;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    ctl_d = ctl_q;
    res_d = res_q;
    zero_d = zero_q;
    ill_d = ill_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (legal) begin
          a_d = in_a;
          b_d = in_b;
          ctl_d = dec;
          cnt_d = dec == 3'b101 ? CW'(MUL_LATENCY - 1) : '0;
          state_d = EXEC;
        end else begin
          res_d = '0;
          zero_d = 1'b1;
          ill_d = 1'b1;
          state_d = DONE;
        end
      end
      EXEC: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        res_d = alu_result_in;
        zero_d = alu_zero_in;
        ill_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      ctl_q <= ctl_d;
      res_q <= res_d;
      zero_q <= zero_d;
      ill_q <= ill_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_control = ctl_q;
  assign out_result = res_q;
  assign out_zero = zero_q;
  assign out_illegal = ill_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: table, random and corner-case checks of alu_issue_unit against a behavioural model
module tb_alu_issue_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid, in_valid2, out_ready, out_ready2;
  logic [1:0] in_alu_op;
  logic [5:0] in_funct;
  logic [31:0] in_a, in_b;
  logic in_ready, out_valid, out_zero, out_illegal, alu_zero_in;
  logic [31:0] alu_a, alu_b, alu_result_in, out_result;
  logic [2:0] alu_control;
  logic in_ready2, out_valid2, out_zero2, out_illegal2, alu_zero_in2;
  logic [31:0] alu_a2, alu_b2, alu_result_in2, out_result2;
  logic [2:0] alu_control2;
  int checks = 0, failures = 0, cyc = 0;
  logic [2:0] last_ctl;
  alu_issue_unit #(.MUL_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result_in(alu_result_in), .alu_zero_in(alu_zero_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal));
  alu_issue_unit #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2),
    .alu_result_in(alu_result_in2), .alu_zero_in(alu_zero_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_result(out_result2),
    .out_zero(out_zero2), .out_illegal(out_illegal2));
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b110: return a - b;
      3'b101: return a * b;
      3'b111: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign alu_result_in = alu_f(alu_a, alu_b, alu_control);
  assign alu_zero_in = alu_result_in == 32'd0;
  assign alu_result_in2 = alu_f(alu_a2, alu_b2, alu_control2);
  assign alu_zero_in2 = alu_result_in2 == 32'd0;
  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [31:0] a, b;
    int hold;
    logic [2:0] ctl;
    logic [31:0] res;
    logic z, ill;
    int lat;
  } vec_t;
  vec_t tbl[12];
  vec_t m;
  function automatic vec_t model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [2:0] prev);
    vec_t e;
    e.op = op; e.f = f; e.a = a; e.b = b; e.hold = 0;
    e.ill = 1'b0; e.lat = 1; e.ctl = prev; e.res = 32'd0;
    if (op == 2'b00) begin e.ctl = 3'b010; e.res = a + b; end
    else if (op == 2'b01) begin e.ctl = 3'b110; e.res = a - b; end
    else if (op == 2'b10 && f == 6'b100000) begin e.ctl = 3'b010; e.res = a + b; end
    else if (op == 2'b10 && f == 6'b100010) begin e.ctl = 3'b110; e.res = a - b; end
    else if (op == 2'b10 && f == 6'b100100) begin e.ctl = 3'b000; e.res = a & b; end
    else if (op == 2'b10 && f == 6'b100101) begin e.ctl = 3'b001; e.res = a | b; end
    else if (op == 2'b10 && f == 6'b101010) begin e.ctl = 3'b111; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
    else if (op == 2'b10 && f == 6'b011000) begin e.ctl = 3'b101; e.res = a * b; e.lat = 4; end
    else begin e.ill = 1'b1; e.lat = 0; end
    e.z = e.ill ? 1'b1 : e.res == 32'd0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic run_instr(input vec_t v, input string tag);
    int n, lat;
    logic [31:0] a0, b0;
    logic st, st2;
    @(negedge clk);
    in_alu_op = v.op; in_funct = v.f; in_a = v.a; in_b = v.b;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_ctl"}, {29'b0, alu_control}, {29'b0, v.ctl});
    if (!v.ill) begin
      chk({tag, "_alu_a"}, alu_a, v.a);
      chk({tag, "_alu_b"}, alu_b, v.b);
    end
    a0 = alu_a; b0 = alu_b; lat = 0; st = 1'b1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (alu_a !== a0 || alu_b !== b0 || alu_control !== v.ctl || (!out_valid && in_ready)) st = 1'b0;
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_exec_stable"}, {31'b0, st}, 32'd1);
    chk({tag, "_result"}, out_result, v.res);
    chk({tag, "_zero_illegal"}, {30'b0, out_zero, out_illegal}, {30'b0, v.z, v.ill});
    st2 = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_result !== v.res || out_zero !== v.z || out_illegal !== v.ill) st2 = 1'b0;
    end
    if (v.hold > 0) chk({tag, "_hold_stable"}, {31'b0, st2}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ready_after_hs"}, {30'b0, in_ready, out_valid}, 32'd2);
    if (!v.ill) last_ctl = v.ctl;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, {30'b0, in_ready, out_valid}, 32'd2);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_out"}, {out_result[28:0], alu_control}, 32'd0);
    chk({tag, "_zero_illegal"}, {30'b0, out_zero, out_illegal}, 32'd0);
  endtask
  bit mon = 1'b0;
  int acc_q[$], hs_q[$];
  logic [31:0] rs_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    #1;
    if (mon) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) begin hs_q.push_back(cyc); rs_q.push_back(out_result); end
    end
  end
  initial begin
    int n, lat;
    logic seen;
    logic [5:0] flist[8];
    flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'b000111, 6'b111111};
    tbl[0]  = '{2'b10, 6'b100000, 32'd5, 32'd7, 0, 3'b010, 32'd12, 1'b0, 1'b0, 1};
    tbl[1]  = '{2'b01, 6'b000000, 32'h1234, 32'h1234, 3, 3'b110, 32'd0, 1'b1, 1'b0, 1};
    tbl[2]  = '{2'b10, 6'b011000, 32'd6, 32'd7, 1, 3'b101, 32'd42, 1'b0, 1'b0, 4};
    tbl[3]  = '{2'b10, 6'b000111, 32'd1, 32'd2, 0, 3'b101, 32'd0, 1'b1, 1'b1, 0};
    tbl[4]  = '{2'b11, 6'b100000, 32'd3, 32'd4, 2, 3'b101, 32'd0, 1'b1, 1'b1, 0};
    tbl[5]  = '{2'b00, 6'b111111, 32'd100, 32'hFFFF_FFFC, 0, 3'b010, 32'd96, 1'b0, 1'b0, 1};
    tbl[6]  = '{2'b10, 6'b100010, 32'd3, 32'd5, 0, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    tbl[7]  = '{2'b10, 6'b100100, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 3'b000, 32'h0F00_0F00, 1'b0, 1'b0, 1};
    tbl[8]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0, 3'b111, 32'd1, 1'b0, 1'b0, 1};
    tbl[9]  = '{2'b10, 6'b101010, 32'd5, 32'hFFFF_FFFE, 0, 3'b111, 32'd0, 1'b1, 1'b0, 1};
    tbl[10] = '{2'b10, 6'b100101, 32'hF0, 32'h0F, 0, 3'b001, 32'hFF, 1'b0, 1'b0, 1};
    tbl[11] = '{2'b10, 6'b011000, 32'd10000, 32'd70000, 0, 3'b101, 32'h29B9_2700, 1'b0, 1'b0, 4};
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    in_alu_op = '0; in_funct = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("reset");
    last_ctl = 3'b000;
    in_alu_op = 2'b10; in_funct = 6'b011000; in_a = 32'd6; in_b = 32'd7;
    in_valid2 = 1'b1;
    chk("lat1_in_ready", {31'b0, in_ready2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("lat1_ctl", {29'b0, alu_control2}, 32'd5);
    lat = 0;
    while (!out_valid2 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("lat1_latency", lat, 1);
    chk("lat1_result", out_result2, 32'd42);
    out_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("lat1_ready_after_hs", {30'b0, in_ready2, out_valid2}, 32'd2);
    for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 40; i++) begin
      m = model($urandom_range(0, 5) == 0 ? 2'b11 : 2'($urandom_range(0, 2)), flist[$urandom_range(0, 7)],
                $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom,
                $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom, last_ctl);
      m.hold = $urandom_range(0, 2);
      run_instr(m, $sformatf("rnd%0d", i));
    end
    @(negedge clk);
    acc_q.delete(); hs_q.delete(); rs_q.delete();
    mon = 1'b1;
    in_alu_op = 2'b10; in_funct = 6'b101010; in_a = 32'd3; in_b = 32'd9;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (acc_q.size() == 0 && n < 20) begin @(negedge clk); #2; n++; end
    @(negedge clk);
    in_funct = 6'b100101; in_a = 32'hF0; in_b = 32'h0F;
    n = 0;
    while (hs_q.size() < 2 && n < 30) begin @(negedge clk); #2; n++; end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    mon = 1'b0;
    chk("b2b_result_count", rs_q.size(), 2);
    chk("b2b_accept_count", acc_q.size(), 2);
    if (rs_q.size() >= 2 && acc_q.size() >= 2) begin
      chk("b2b_slt_result", rs_q[0], 32'd1);
      chk("b2b_or_result", rs_q[1], 32'hFF);
      chk("b2b_second_accept_cycle", acc_q[1], hs_q[0] + 1);
    end
    repeat (2) @(negedge clk);
    in_alu_op = 2'b10; in_funct = 6'b011000; in_a = 32'd6; in_b = 32'd7;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_mul_ctl", {29'b0, alu_control}, 32'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("abort");
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("abort_no_result", {31'b0, seen}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front-end that drives the ALU's operand/control interface.
- Accepts one instruction (alu_op, funct, two 32-bit operands) per valid/ready handshake.
- Decodes alu_op/funct into the 3-bit ALU control code and drives registered operands to the ALU.
- Holds them for a fixed latency (longer for multiply), captures the ALU's result and zero flag, and returns them over a second valid/ready handshake.

Parameters:
- MUL_LATENCY, 4, cycles operands are held for multiply before capture; legal values >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  unit can accept an instruction; high only in IDLE.
- in_alu_op  input  2  00 = add (lw/sw), 01 = subtract (beq), 10 = R-type (use funct), 11 = illegal.
- in_funct  input  6  R-type funct field.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- alu_a  output  32  registered operand A to ALU.
- alu_b  output  32  registered operand B to ALU.
- alu_control  output  3  registered control to ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 101 MUL, 111 SLT.
- alu_result_in  input  32  ALU result.
- alu_zero_in  input  1  ALU zero flag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  captured result.
- out_zero  output  1  captured zero flag.
- out_illegal  output  1  instruction was undecodable.

Behaviour:
- States: IDLE, EXEC, DONE; 2-bit state register plus a down-counter sized for MUL_LATENCY-1.
- in_ready = (state == IDLE), combinational from state; out_valid = (state == DONE).
- Reset, checked at the clock edge:
  - state = IDLE, counter = 0.
  - alu_a = 0, alu_b = 0, alu_control = 000.
  - out_result = 0, out_zero = 0, out_illegal = 0.
  - Reset overrides any in-flight operation; no result is delivered for it.
- Decode:
  - alu_op 00 -> 010.
  - alu_op 01 -> 110.
  - alu_op 10 with funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; 011000 -> 101.
  - Any other funct with alu_op 10, or alu_op 11, is illegal.
- IDLE, accept (in_valid & in_ready) at edge T0:
  - Legal instruction: load alu_a/alu_b/alu_control, go to EXEC.
    - Counter = MUL_LATENCY-1 for code 101.
    - Counter = 0 for every other code.
  - Illegal instruction: alu_a/alu_b/alu_control unchanged; out_result = 0, out_zero = 1, out_illegal = 1; go straight to DONE, so out_valid is high in the cycle after T0.
- EXEC:
  - Counter nonzero: decrement.
  - Counter zero: capture out_result = alu_result_in, out_zero = alu_zero_in, out_illegal = 0; go to DONE.
  - alu_a/alu_b/alu_control are stable for the whole of EXEC.
- Latency from accept edge to capture edge: 1 cycle for non-MUL, MUL_LATENCY cycles for MUL. out_valid rises in the cycle after the capture edge.
- DONE:
  - out_result, out_zero, out_illegal are held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge -> IDLE; in_ready is high in the next cycle.
- No overlap: at most one instruction in flight. A new accept is possible no earlier than the cycle after the result handshake.
- Outside DONE, out_result/out_zero/out_illegal keep their last captured values; they are valid only while out_valid=1.
- in_valid while not in IDLE is ignored; the producer must hold the instruction until in_ready.
- Arithmetic is done by the external ALU; this unit adds no width extension, and operands pass through unmodified.

Test Plan:
1. Reset, then R-type add (alu_op 10, funct 100000, A=5, B=7):
   - in_ready=1 after reset; alu_control=010 after accept.
   - out_valid rises 2 cycles after the accept edge, with out_result=12, out_zero=0, out_illegal=0.
2. beq compare (alu_op 01, A=B=0x1234):
   - alu_control=110; out_result=0, out_zero=1.
   - With out_ready held low for 3 cycles, out_valid stays high, outputs stay stable, and in_ready stays low.
3. MUL (funct 011000, A=6, B=7, MUL_LATENCY=4):
   - alu_control=101, with alu_a/alu_b stable for 4 cycles.
   - out_valid rises 5 cycles after accept, with out_result=42.
   - Repeat with MUL_LATENCY=1: out_valid rises 2 cycles after accept.
4. Illegal (alu_op 10, funct 000111; then alu_op 11):
   - out_valid in the next cycle, with out_illegal=1, out_result=0, out_zero=1.
   - alu_control keeps its previous value.
5. Back-to-back: SLT (A=3, B=9) then OR (A=0xF0, B=0x0F), with in_valid held continuously and out_ready=1:
   - Results are 1 then 0xFF.
   - The second accept occurs in the cycle after the first result handshake.
6. Reset during a MUL EXEC (reset asserted 2 cycles after accept):
   - Next cycle: state IDLE, in_ready=1, out_valid=0, all outputs at their reset values.
   - No result is delivered for the aborted MUL.
